// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save stream accumulator: FSM state encoding
// and default operand/accumulator widths.
package csa_pkg;

    localparam int CSA_DATA_W = 8;
    localparam int CSA_ACC_W  = 16;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } csa_state_e;

endpackage

// File: rtl/csa_compress_3to2.sv
// One row of W independent full adders: three equal-weight inputs reduce to a
// sum vector and a majority (carry) vector that is not yet shifted to its weight.
module csa_compress_3to2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] m
);

    assign s = a ^ b ^ c;
    assign m = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Packet accumulator holding its running total in carry-save form; one carry-propagate
// add per packet. Define CSA_ACC_SAT_EN to saturate out_data on overflow instead of wrapping.
module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter int DATA_W = CSA_DATA_W,
    parameter int ACC_W  = CSA_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    // Both ports: a beat transfers on a rising edge where valid & ready are both 1;
    // the source holds valid and its payload until that edge, and ready never waits on valid.

    csa_state_e       state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] car_q, car_d;
    logic             drop_q, drop_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] d_ext;
    logic [ACC_W-1:0] csa_s;
    logic [ACC_W-1:0] csa_m;
    logic [ACC_W:0]   full_sum;
    logic             resolve_ovf;

    assign d_ext = ACC_W'(in_data);

    csa_compress_3to2 #(.W(ACC_W)) u_compress (
        .a (sum_q),
        .b (car_q),
        .c (d_ext),
        .s (csa_s),
        .m (csa_m)
    );

    // Majority bits that would shift past the MSB are true carries of weight 2^ACC_W.
    assign full_sum    = {1'b0, sum_q} + {1'b0, car_q};
    assign resolve_ovf = drop_q | full_sum[ACC_W];

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        car_d      = car_q;
        drop_d     = drop_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sum_d  = csa_s;
                    car_d  = {csa_m[ACC_W-2:0], 1'b0};
                    drop_d = drop_q | csa_m[ACC_W-1];
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_ovf_d = resolve_ovf;
`ifdef CSA_ACC_SAT_EN
                out_data_d = resolve_ovf ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
                out_data_d = full_sum[ACC_W-1:0];
`endif
                state_d = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    sum_d   = '0;
                    car_d   = '0;
                    drop_d  = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            sum_q      <= '0;
            car_q      <= '0;
            drop_q     <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            car_q      <= car_d;
            drop_q     <= drop_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_data = out_data_q;
    assign out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator at DATA_W=8, ACC_W=10, with a short
// randomized back-to-back phase checked against an integer sum.
module tb_csa_stream_accumulator;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 10;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;

    int n_checks = 0;
    int n_bad    = 0;
    logic [ACC_W:0] exp_q[$];
    logic rand_done;

    csa_stream_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got=timeout need=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // {ovf, data} expected for an exact unsigned packet total
    function automatic logic [ACC_W:0] model(input int unsigned total);
        logic             ovf;
        logic [ACC_W-1:0] d;
        ovf = (total >= (1 << ACC_W));
        d   = total[ACC_W-1:0];
`ifdef CSA_ACC_SAT_EN
        if (ovf) d = '1;
`endif
        return {ovf, d};
    endfunction

    // driver: present one operand and hold it until accepted
    task automatic send(input logic [DATA_W-1:0] d, input logic last);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: every result handshake must match the head of exp_q
    always @(negedge clk) begin
        logic [ACC_W:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(out_data), 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("res_data", 32'(out_data), 32'(e[ACC_W-1:0]));
                check("res_ovf", 32'(out_ovf), 32'(e[ACC_W]));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(posedge clk);
        #1;

        // 3 + 5 + 7 with latency checks
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 10'd15});
        send(8'd3, 1'b0);
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        @(negedge clk);
        check("lat_resolve_valid", 32'(out_valid), 32'd0);
        check("lat_resolve_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("lat_output_valid", 32'(out_valid), 32'd1);
        check("lat_output_data", 32'(out_data), 32'd15);
        check("lat_output_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_hs_ready", 32'(in_ready), 32'd1);
        check("after_hs_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // 4 x 255 = 1020, no overflow
        exp_q.push_back({1'b0, 10'd1020});
        for (int i = 0; i < 4; i++) send(8'd255, i == 3);
        wait_cycles(3);

        // 5 x 255 = 1275 overflows 10 bits
`ifdef CSA_ACC_SAT_EN
        exp_q.push_back({1'b1, 10'd1023});
`else
        exp_q.push_back({1'b1, 10'd251});
`endif
        for (int i = 0; i < 5; i++) send(8'd255, i == 4);
        wait_cycles(3);

        // backpressure on a pending result of 15
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 10'd15});
        send(8'd3, 1'b0);
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        wait_cycles(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'd15);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_cycles(1);
        exp_q.push_back({1'b0, 10'd200});
        send(8'd200, 1'b1);
        wait_cycles(3);

        // reset in the middle of a packet
        send(8'd100, 1'b0);
        send(8'd100, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midpkt_rst_ready", 32'(in_ready), 32'd1);
        check("midpkt_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 10'd1});
        send(8'd1, 1'b1);
        wait_cycles(3);

        // reset while a result is pending: out_valid must drop at once
        out_ready = 1'b0;
        send(8'd9, 1'b1);
        wait_cycles(1);
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 10'd6});
        send(8'd2, 1'b0);
        send(8'd4, 1'b1);
        wait_cycles(3);

        // randomized back-to-back packets with random gaps and backpressure
        fork
            begin
                for (int p = 0; p < 8; p++) begin
                    int unsigned    total;
                    int             len;
                    logic [DATA_W-1:0] ops[$];
                    len   = $urandom_range(1, 40);
                    total = 0;
                    ops.delete();
                    for (int k = 0; k < len; k++) begin
                        logic [DATA_W-1:0] v;
                        v = DATA_W'($urandom_range(0, 255));
                        ops.push_back(v);
                        total += v;
                    end
                    exp_q.push_back(model(total));
                    for (int k = 0; k < len; k++) begin
                        if ($urandom_range(0, 3) == 0) wait_cycles(1);
                        send(ops[k], k == len - 1);
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join

        for (int b = 0; b < 500 && exp_q.size() != 0; b++) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
